// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_pkg
// Description : Shared types and helpers for the 4-port switch scheduler
//               and its per-input header parser.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_pkg;

    localparam int NUM_PORTS = 4;

    typedef logic [3:0] port_mask_t;

    // Packet classes produced by the header parser
    typedef enum logic [1:0] {
        SDP = 2'd0,     // single destination
        MDP = 2'd1,     // multiple (not all) destinations
        BDP = 2'd2,     // broadcast to every port
        ERR = 2'd3      // malformed header
    } p_type;

    // Population count of a port mask (0..4)
    function automatic logic [2:0] count_ones(input port_mask_t m);
        logic [2:0] n;
        n = '0;
        for (int b = 0; b < 4; b++) begin
            n = n + {2'b00, m[b]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/parser.sv
`default_nettype none
// ============================================================================
// Module      : parser
// Description : Combinational header classifier for one switch input.
//               A header is malformed when the source is not one-hot, the
//               target is empty, or a non-broadcast target includes the
//               source port. A full target mask is a broadcast.
// Revision    : 1.0 - initial release
// ============================================================================
module parser
    import switch_pkg::*;
(
    input  port_mask_t pkt_source,
    input  port_mask_t pkt_target,
    output p_type      pkt_type,
    output logic       pkt_valid
);

    // Classify the header; broadcast tolerates the source bit because the
    // scheduler strips it from the effective mask.
    always_comb begin
        pkt_type = ERR;
        if ((count_ones(pkt_source) != 3'd1) || (pkt_target == '0)) begin
            pkt_type = ERR;
        end else if (pkt_target == 4'b1111) begin
            pkt_type = BDP;
        end else if ((pkt_target & pkt_source) != '0) begin
            pkt_type = ERR;
        end else if (count_ones(pkt_target) == 3'd1) begin
            pkt_type = SDP;
        end else begin
            pkt_type = MDP;
        end
    end

    assign pkt_valid = (pkt_type != ERR);

endmodule
`default_nettype wire

// File: rtl/switch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : switch_scheduler
// Description : Output-port scheduler for the 4-port switch. Drops malformed
//               headers, grants atomic ownership of all outputs in a valid
//               packet's mask using round-robin with a head-of-line
//               reservation, and holds ownership until end-of-packet.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_scheduler
    import switch_pkg::port_mask_t, switch_pkg::p_type, switch_pkg::BDP,
           switch_pkg::count_ones;
#(
    parameter int NUM_PORTS = 4,
    parameter int CNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic       [NUM_PORTS-1:0]   req_valid,
    input  port_mask_t [NUM_PORTS-1:0]   req_source,
    input  port_mask_t [NUM_PORTS-1:0]   req_target,
    output logic       [NUM_PORTS-1:0]   req_ready,
    output logic       [NUM_PORTS-1:0]   req_drop,
    input  logic       [NUM_PORTS-1:0]   eop,
    output port_mask_t [NUM_PORTS-1:0]   out_sel,
    output port_mask_t [NUM_PORTS-1:0]   in_owned,
    output logic       [CNT_W-1:0]       drop_cnt
);

    // The classification and the 2-bit scan pointer only make sense for 4 ports
    if (NUM_PORTS != 4) begin : g_bad_num_ports
        $error("switch_scheduler: NUM_PORTS must be 4");
    end

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    localparam logic [CNT_W+2:0] c_cnt_max = {3'b000, {CNT_W{1'b1}}};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]                 state_q [NUM_PORTS];
    logic [0:0]                 state_d [NUM_PORTS];
    port_mask_t [NUM_PORTS-1:0] in_owned_q, in_owned_d;
    port_mask_t [NUM_PORTS-1:0] out_sel_q, out_sel_d;
    logic [1:0]                 rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]           drop_cnt_q, drop_cnt_d;

    // ------------------------------------------------------------------------
    // Classification
    // ------------------------------------------------------------------------
    p_type                      pkt_type [NUM_PORTS];
    logic [NUM_PORTS-1:0]       pkt_valid;
    port_mask_t [NUM_PORTS-1:0] eff_mask;
    logic [NUM_PORTS-1:0]       is_idle;
    logic [NUM_PORTS-1:0]       cand;
    logic [NUM_PORTS-1:0]       drop_vec;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_parser
        parser u_parser (
            .pkt_source (req_source[i]),
            .pkt_target (req_target[i]),
            .pkt_type   (pkt_type[i]),
            .pkt_valid  (pkt_valid[i])
        );

        // Broadcast never echoes back to its own source port
        assign eff_mask[i] = (pkt_type[i] == BDP) ? (req_target[i] & ~req_source[i])
                                                  : req_target[i];
        assign is_idle[i]  = (state_q[i] == S_IDLE);
        assign cand[i]     = is_idle[i] & req_valid[i] & pkt_valid[i];
        assign drop_vec[i] = is_idle[i] & req_valid[i] & ~pkt_valid[i];
    end

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    port_mask_t busy;
    logic       win_found;
    logic [1:0] win_idx;

    // Outputs freed by eop this cycle are still busy here; they become
    // arbitrable only once in_owned_q has dropped them.
    always_comb begin
        busy = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            busy = busy | in_owned_q[i];
        end
    end

    // Round-robin scan from rr_ptr; a blocked head reserves its mask so later
    // candidates cannot keep stealing the outputs it is waiting for.
    always_comb begin
        logic       head_seen;
        port_mask_t reserved;
        logic [1:0] idx;
        win_found = 1'b0;
        win_idx   = 2'd0;
        head_seen = 1'b0;
        reserved  = '0;
        idx       = 2'd0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = rr_ptr_q + 2'(k);
            if (cand[idx] && !win_found) begin
                if (!head_seen) begin
                    head_seen = 1'b1;
                    if ((eff_mask[idx] & busy) == '0) begin
                        win_found = 1'b1;
                        win_idx   = idx;
                    end else begin
                        reserved = eff_mask[idx];
                    end
                end else if ((eff_mask[idx] & (busy | reserved)) == '0) begin
                    win_found = 1'b1;
                    win_idx   = idx;
                end
            end
        end
    end

    // Header handshake: drops are independent of arbitration; nothing is
    // acknowledged while reset is asserted.
    always_comb begin
        req_ready = '0;
        req_drop  = '0;
        if (rst_n) begin
            req_drop = drop_vec;
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_ready[i] = drop_vec[i] | (win_found && (win_idx == 2'(i)));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------------
    // Per-input FSM and ownership: grant takes the whole mask, eop frees it
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            state_d[i]    = state_q[i];
            in_owned_d[i] = in_owned_q[i];
            if (state_q[i] == S_ACTIVE) begin
                if (eop[i]) begin
                    state_d[i]    = S_IDLE;
                    in_owned_d[i] = '0;
                end
            end else if (win_found && (win_idx == 2'(i))) begin
                state_d[i]    = S_ACTIVE;
                in_owned_d[i] = eff_mask[i];
            end
        end
    end

    // Output view is the transpose of the ownership matrix
    always_comb begin
        out_sel_d = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                out_sel_d[o][i] = in_owned_d[i][o];
            end
        end
    end

    // Pointer moves just past the winner; holds when nobody wins
    always_comb begin
        rr_ptr_d = win_found ? (win_idx + 2'd1) : rr_ptr_q;
    end

    // Saturating drop counter; sum is wide enough for four drops at once
    always_comb begin
        logic [CNT_W+2:0] drop_sum;
        drop_sum   = {3'b000, drop_cnt_q} + {{CNT_W{1'b0}}, count_ones(drop_vec)};
        drop_cnt_d = (drop_sum > c_cnt_max) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end

    // State registers with asynchronous clear of all ownership
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= S_IDLE;
            end
            in_owned_q <= '0;
            out_sel_q  <= '0;
            rr_ptr_q   <= 2'd0;
            drop_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= state_d[i];
            end
            in_owned_q <= in_owned_d;
            out_sel_q  <= out_sel_d;
            rr_ptr_q   <= rr_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign out_sel  = out_sel_q;
    assign in_owned = in_owned_q;
    assign drop_cnt = drop_cnt_q;

    // ------------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------------
    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_chk_sel
        a_sel_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
            $onehot0(out_sel_q[o]));
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_chk_own
        a_owned_iff_active: assert property (@(posedge clk) disable iff (!rst_n)
            ((in_owned_q[i] != '0) == (state_q[i] == S_ACTIVE)));
        for (genvar j = i + 1; j < NUM_PORTS; j++) begin : g_pair
            a_disjoint: assert property (@(posedge clk) disable iff (!rst_n)
                ((in_owned_q[i] & in_owned_q[j]) == '0));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_switch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_scheduler
// Description : Directed self-checking bench for switch_scheduler (CNT_W=3).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_switch_scheduler;

    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req_valid;
    logic [3:0][3:0]  req_source;
    logic [3:0][3:0]  req_target;
    logic [3:0]       req_ready;
    logic [3:0]       req_drop;
    logic [3:0]       eop;
    logic [3:0][3:0]  out_sel;
    logic [3:0][3:0]  in_owned;
    logic [CNT_W-1:0] drop_cnt;

    int n_checks;
    int n_fail;

    switch_scheduler #(
        .NUM_PORTS (4),
        .CNT_W     (CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_source (req_source),
        .req_target (req_target),
        .req_ready  (req_ready),
        .req_drop   (req_drop),
        .eop        (eop),
        .out_sel    (out_sel),
        .in_owned   (in_owned),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Move to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        eop       = '0;
        tick();
        tick();
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        req_valid  = '0;
        req_source = '0;
        req_target = '0;
        eop        = '0;
        rst_n      = 1'b1;
        #1 rst_n   = 1'b0;

        // Reset: malformed headers present but nothing is acknowledged
        req_valid  = 4'b1111;
        req_source = {4'b0011, 4'b0011, 4'b0011, 4'b0011};
        req_target = {4'b0001, 4'b0001, 4'b0001, 4'b0001};
        #2;
        chk_eq("rst_ready",    req_ready, 4'b0000);
        chk_eq("rst_drop",     req_drop,  4'b0000);
        chk_eq("rst_out_sel",  out_sel,   16'h0000);
        chk_eq("rst_in_owned", in_owned,  16'h0000);
        chk_eq("rst_drop_cnt", drop_cnt,  3'd0);
        tick();
        tick();
        req_valid = '0;
        #3;
        rst_n = 1'b1;

        // Drop: source overlaps target
        tick();
        req_valid     = 4'b0001;
        req_source[0] = 4'b0001;
        req_target[0] = 4'b0001;
        #3;
        chk_eq("drop_ready", req_ready, 4'b0001);
        chk_eq("drop_drop",  req_drop,  4'b0001);
        chk_eq("drop_cnt0",  drop_cnt,  3'd0);
        tick();
        req_valid = '0;
        #3;
        chk_eq("drop_cnt1",    drop_cnt, 3'd1);
        chk_eq("drop_out_sel", out_sel,  16'h0000);

        // Broadcast from input 2 excludes its own port
        tick();
        req_valid     = 4'b0100;
        req_source[2] = 4'b0100;
        req_target[2] = 4'b1111;
        #3;
        chk_eq("bdp_ready", req_ready, 4'b0100);
        chk_eq("bdp_drop",  req_drop,  4'b0000);
        tick();
        req_valid = '0;
        eop       = 4'b0100;
        #3;
        chk_eq("bdp_owned2", in_owned[2], 4'b1011);
        chk_eq("bdp_sel0",   out_sel[0],  4'b0100);
        chk_eq("bdp_sel1",   out_sel[1],  4'b0100);
        chk_eq("bdp_sel2",   out_sel[2],  4'b0000);
        chk_eq("bdp_sel3",   out_sel[3],  4'b0100);
        tick();
        eop = '0;
        #3;
        chk_eq("bdp_release", in_owned, 16'h0000);

        // Contention from reset: inputs 0 and 1 both want output 3
        do_reset();
        tick();
        req_valid     = 4'b0011;
        req_source[0] = 4'b0100;
        req_target[0] = 4'b1000;
        req_source[1] = 4'b0001;
        req_target[1] = 4'b1000;
        #3;
        chk_eq("cont_ready0", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0010;
        eop       = 4'b0001;
        #3;
        chk_eq("cont_sel3_in0", out_sel[3],  4'b0001);
        chk_eq("cont_owned0",   in_owned[0], 4'b1000);
        chk_eq("cont_blocked",  req_ready,   4'b0000);
        tick();
        eop = '0;
        #3;
        chk_eq("cont_freed",  in_owned,  16'h0000);
        chk_eq("cont_ready1", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        eop       = 4'b0010;
        #3;
        chk_eq("cont_sel3_in1", out_sel[3],  4'b0010);
        chk_eq("cont_owned1",   in_owned[1], 4'b1000);
        // rr_ptr should be 2: input 3 beats input 0 for the same output
        tick();
        eop           = '0;
        req_valid     = 4'b1001;
        req_source[0] = 4'b0001;
        req_target[0] = 4'b0100;
        req_source[3] = 4'b0001;
        req_target[3] = 4'b0100;
        #3;
        chk_eq("rr_ptr2_ready", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        eop       = 4'b1000;
        #3;
        chk_eq("rr_ptr2_sel2", out_sel[2], 4'b1000);

        // Starvation guard: input 3 holds output 0, rr_ptr back at 0
        tick();
        eop           = '0;
        req_valid     = 4'b1000;
        req_source[3] = 4'b0010;
        req_target[3] = 4'b0001;
        #3;
        chk_eq("stv_ready3", req_ready, 4'b1000);
        tick();
        req_valid     = 4'b0011;
        req_source[0] = 4'b0100;
        req_target[0] = 4'b0011;
        req_source[1] = 4'b0001;
        req_target[1] = 4'b0010;
        #3;
        chk_eq("stv_owned3", in_owned[3], 4'b0001);
        chk_eq("stv_reserv", req_ready,   4'b0000);
        tick();
        eop = 4'b1000;
        #3;
        chk_eq("stv_owned1_none", in_owned[1], 4'b0000);
        chk_eq("stv_eop_cycle",   req_ready,   4'b0000);
        tick();
        eop = '0;
        #3;
        chk_eq("stv_released", in_owned[3], 4'b0000);
        chk_eq("stv_ready0",   req_ready,   4'b0001);
        tick();
        req_valid = 4'b0010;
        #3;
        chk_eq("stv_owned0", in_owned[0], 4'b0011);
        chk_eq("stv_sel0",   out_sel[0],  4'b0001);
        chk_eq("stv_sel1",   out_sel[1],  4'b0001);
        chk_eq("stv_in1_wait", req_ready, 4'b0000);
        tick();
        req_valid = '0;
        eop       = 4'b0001;
        tick();
        eop = '0;

        // Saturation and simultaneous drops: source not one-hot
        tick();
        req_valid  = 4'b1111;
        req_source = {4'b0011, 4'b0011, 4'b0011, 4'b0011};
        req_target = {4'b0100, 4'b0100, 4'b0100, 4'b0100};
        #3;
        chk_eq("sat_ready", req_ready, 4'b1111);
        chk_eq("sat_drop",  req_drop,  4'b1111);
        tick();
        #3;
        chk_eq("sat_cnt4", drop_cnt, 3'd4);
        tick();
        req_valid = 4'b0001;
        #3;
        chk_eq("sat_cnt8", drop_cnt, 3'd7);
        tick();
        req_valid = '0;
        #3;
        chk_eq("sat_cnt9", drop_cnt, 3'd7);

        // Async reset with inputs 0 and 2 active
        tick();
        req_valid     = 4'b0101;
        req_source[0] = 4'b0010;
        req_target[0] = 4'b0001;
        req_source[2] = 4'b0001;
        req_target[2] = 4'b0100;
        #3;
        chk_eq("ar_ready2", req_ready, 4'b0100);
        tick();
        #3;
        chk_eq("ar_ready0", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        #3;
        chk_eq("ar_owned0", in_owned[0], 4'b0001);
        chk_eq("ar_owned2", in_owned[2], 4'b0100);
        rst_n = 1'b0;
        #1;
        chk_eq("ar_owned_clr", in_owned, 16'h0000);
        chk_eq("ar_sel_clr",   out_sel,  16'h0000);
        #3;
        rst_n = 1'b1;
        tick();
        req_valid     = 4'b0011;
        req_source[0] = 4'b0100;
        req_target[0] = 4'b1000;
        req_source[1] = 4'b0001;
        req_target[1] = 4'b1000;
        #3;
        chk_eq("ar_fresh_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        #3;
        chk_eq("ar_fresh_sel3", out_sel[3], 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/switch_scheduler.md
# switch_scheduler

Central output-port scheduler for the 4-port switch. It sits between the four input-port header stages and the crossbar. Each header is classified by a per-port `parser`. Invalid packets are dropped. Valid packets are granted atomic ownership of every output in their destination set, using round-robin with a starvation guard. Ownership is held until the input signals end-of-packet.

## Interface
Parameters:
- `NUM_PORTS`, 4: port count. Fixed at 4 because of the `p_type` classification; any other value is a synthesis error.
- `CNT_W`, 8: width of the saturating drop counter.

Ports:
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 4: input i presents a header.
- `req_source` in 4x4: one-hot source field per input.
- `req_target` in 4x4: target mask per input.
- `req_ready` out 4: header handshake; the header is consumed when `req_valid[i] & req_ready[i]`. Combinational.
- `req_drop` out 4: qualifies `req_ready[i]`; the packet is discarded and no outputs are owned.
- `eop` in 4: input i's last data beat is transferred this cycle.
- `out_sel` out 4x4: `out_sel[o]` is the one-hot input driving output o; 0 when the output is free. Registered.
- `in_owned` out 4x4: `in_owned[i]` is the mask of outputs owned by input i. Registered.
- `drop_cnt` out CNT_W: number of dropped headers, saturating.

## Operation
- Per-input FSM with two states:
  - IDLE → ACTIVE on a valid grant handshake.
  - ACTIVE → IDLE on `eop[i]`.
  - A dropped header leaves the input in IDLE.
- Classification: each input drives its own `parser`, producing `pkt_type` and `pkt_valid`.
- Effective mask:
  - `req_target & ~req_source` for BDP (no echo to the source port).
  - `req_target` otherwise.
- Drop path: an IDLE input with `req_valid=1` and `pkt_valid=0` gets `req_ready=1` and `req_drop=1` in the same cycle, independent of arbitration. All four inputs may drop in the same cycle.
- Grant path: at most one valid grant per cycle.
  - Scan order starts at `rr_ptr` (2-bit, reset 0) and wraps modulo 4.
  - Candidates are IDLE inputs with `req_valid=1` and `pkt_valid=1`.
  - The first candidate in scan order is the *head*.
  - If the head's mask has no overlap with busy outputs, the head wins.
  - Otherwise the head's mask is *reserved*. The first later candidate whose mask overlaps neither the busy outputs nor the reservation wins.
  - Grants are atomic: an input owns all outputs of its mask or none. Partial multicast is never granted.
- On a win: `req_ready[i]=1` and `req_drop[i]=0`. From the next cycle, `out_sel` and `in_owned` reflect ownership and `rr_ptr` = winner+1 (mod 4).
- If there is no winner, `rr_ptr` holds.
- Release: `eop[i]` in ACTIVE frees `in_owned[i]` at the next edge. The freed outputs are arbitrable in the following cycle, not in the same cycle as `eop`.
- `eop[i]` in IDLE is ignored.
- `req_valid[i]` in ACTIVE is ignored and `req_ready[i]=0`. A new header from that input is considered in the cycle after its release.
- `drop_cnt`:
  - +1 per dropped header.
  - Simultaneous drops add their count.
  - Saturates at 2^CNT_W−1 with no wrap.

## Timing
- Reset values: all FSMs IDLE, `out_sel=0`, `in_owned=0`, `rr_ptr=0`, `drop_cnt=0`.
- `req_ready` and `req_drop` are combinational from inputs and registered state. They are 0 whenever `rst_n=0`.
- Grant latency: handshake in cycle N (0 cycles after `req_valid` if uncontended). Ownership is visible on `out_sel` in N+1.
- Release latency: `eop` in cycle N frees the outputs in N+1. The earliest new grant of those outputs is in N+1, with ownership visible in N+2.
- Reset asserted mid-packet: all ownership is cleared asynchronously. Inputs must restart from a header.
- Invariants checked by assertion:
  - `out_sel[o]` is one-hot or zero.
  - `in_owned` rows are pairwise disjoint.
  - `in_owned[i]` is nonzero iff input i is ACTIVE.

## Structure
- `switch_pkg` holds: the `p_type` enum {SDP, MDP, BDP, ERR}, `NUM_PORTS=4`, and `typedef logic [3:0] port_mask_t`. Both `parser` and `switch_scheduler` import it.
- Sub-module: four instances of the existing `parser`, one per input.
- The arbitration scan is combinational logic local to `switch_scheduler`; it has no separate module.

## Test plan
- Drop: input 0 presents src=0001, tgt=0001 (overlap) → same cycle `req_ready[0]=1`, `req_drop[0]=1`, `drop_cnt=1`, `out_sel` unchanged.
- Broadcast: input 2 presents src=0100, tgt=1111 → handshake. Next cycle `in_owned[2]=1011`, `out_sel[0]=out_sel[1]=out_sel[3]=0100`, `out_sel[2]=0`.
- Contention: inputs 0 and 1 both target 1000 from reset → input 0 wins (`rr_ptr=0`). After `eop[0]`, input 1 is granted one cycle later and `rr_ptr=2`.
- Starvation guard: input 3 owns 0001. With `rr_ptr=0`, input 0 requests 0011 and input 1 requests 0010 → input 1 is blocked by the reservation and nothing is granted. After `eop[3]`, input 0 gets 0011.
- Saturation and simultaneity: 4 simultaneous invalid headers add 4. With CNT_W=3, after 9 drops `drop_cnt=7`.
- Async reset while inputs 0 and 2 are ACTIVE → outputs go to 0 immediately. After release, a fresh header is granted with `rr_ptr=0` ordering.
